rtlola_event_queue: RTL and testbench

Parametrised input-event queue between the stream-input capture and the RTLola evaluation pipeline of the monitor. Every cycle in which any input channel signals new data, or the periodic pacing timer expires, it forms one event (values, arrival mask, periodic flag, timestamp, tag). Each event is stored in a DEPTH-entry FIFO and presented to the evaluator over a valid/ready handshake. It replaces the fixed two-input, single-event-per-cycle queue with configurable channel count, widths, depth, and periodic event injection.

---
 rtl/rtlola_event_queue_pkg.sv | 31 +++
 rtl/rtlola_event_queue_if.sv | 25 ++
 rtl/rtlola_event_queue_fifo.sv | 45 ++++
 rtl/rtlola_event_queue.sv | 115 +++++++++++
 tb/tb_rtlola_event_queue.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/rtlola_event_queue_pkg.sv
// Shared entry layout for the RTLola input-event queue.
// Entry packing, MSB to LSB: data | mask | periodic | timestamp | tag.
package rtlola_queue_pkg;

    localparam int DROP_W = 16;

    function automatic int entry_w(int n, int dw, int tsw, int tagw);
        return n * dw + n + 1 + tsw + tagw;
    endfunction

    function automatic int off_tag();
        return 0;
    endfunction

    function automatic int off_ts(int tagw);
        return tagw;
    endfunction

    function automatic int off_periodic(int tsw, int tagw);
        return tagw + tsw;
    endfunction

    function automatic int off_mask(int tsw, int tagw);
        return tagw + tsw + 1;
    endfunction

    function automatic int off_data(int n, int tsw, int tagw);
        return tagw + tsw + 1 + n;
    endfunction

endpackage

// File: rtl/rtlola_event_queue_if.sv
// Head-of-queue event handshake between the queue (master) and the evaluator (slave).
interface rtlola_event_queue_if #(
    parameter int NUM_INPUTS = 2,
    parameter int DATA_WIDTH = 64,
    parameter int TS_WIDTH   = 32,
    parameter int TAG_WIDTH  = 64
);
    logic [NUM_INPUTS*DATA_WIDTH-1:0] ev_data;
    logic [NUM_INPUTS-1:0]            ev_mask;
    logic                             ev_periodic;
    logic [TS_WIDTH-1:0]              ev_ts;
    logic [TAG_WIDTH-1:0]             ev_tag;
    logic                             ev_valid;
    logic                             ev_ready;

    modport master (
        output ev_data, ev_mask, ev_periodic, ev_ts, ev_tag, ev_valid,
        input  ev_ready
    );

    modport slave (
        input  ev_data, ev_mask, ev_periodic, ev_ts, ev_tag, ev_valid,
        output ev_ready
    );
endinterface

// File: rtl/rtlola_event_queue_fifo.sv
// Generic show-ahead synchronous FIFO; pointers carry one extra wrap bit.
module rtlola_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            if (i_push && !i_pop)      r_level <= r_level + 1'b1;
            else if (i_pop && !i_push) r_level <= r_level - 1'b1;
        end
    end

    // Storage needs no reset: the head is only observed while non-empty.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level = r_level;
endmodule

// File: rtl/rtlola_event_queue.sv
// RTLola input-event queue: forms one event per cycle from input strobes and the
// periodic timer, stamps and tags it, and buffers it for the evaluator.
module rtlola_event_queue
    import rtlola_queue_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int TS_WIDTH   = 32,
    parameter int TAG_WIDTH  = 64,
    parameter int PERIOD     = 1000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] input_data,
    input  logic [NUM_INPUTS-1:0]            new_input,
    rtlola_event_queue_if.master             ev,
    output logic                             q_push,
    output logic                             q_push_valid,
    output logic                             q_pop,
    output logic [$clog2(DEPTH):0]           q_level,
    output logic                             overflow,
    output logic [DROP_W-1:0]                drop_count
);
    localparam int EW       = entry_w(NUM_INPUTS, DATA_WIDTH, TS_WIDTH, TAG_WIDTH);
    localparam int O_TAG    = off_tag();
    localparam int O_TS     = off_ts(TAG_WIDTH);
    localparam int O_PER    = off_periodic(TS_WIDTH, TAG_WIDTH);
    localparam int O_MASK   = off_mask(TS_WIDTH, TAG_WIDTH);
    localparam int O_DATA   = off_data(NUM_INPUTS, TS_WIDTH, TAG_WIDTH);
    localparam int TIMER_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int LAST     = (PERIOD > 0) ? PERIOD - 1 : 0;

    logic [TS_WIDTH-1:0]             r_ts;
    logic [TIMER_W-1:0]              r_timer;
    logic [TAG_WIDTH-1:0]            r_tag;
    logic                            r_overflow;
    logic [DROP_W-1:0]               r_drop;

    logic                            w_tick;
    logic                            w_form;
    logic                            w_pop;
    logic                            w_accept;
    logic                            w_drop;
    logic                            w_full;
    logic                            w_empty;
    logic                            w_valid;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] w_masked;
    logic [EW-1:0]                   w_entry;
    logic [EW-1:0]                   w_head;

    assign w_tick   = (PERIOD != 0) && en && (r_timer == TIMER_W'(LAST));
    // Gated by rst so every output reads 0 while reset is held.
    assign w_form   = rst && en && ((|new_input) || w_tick);
    assign w_valid  = !w_empty;
    assign w_pop    = w_valid && ev.ev_ready && en;
    assign w_accept = w_form && (!w_full || w_pop);
    assign w_drop   = w_form && w_full && !w_pop;

    always_comb begin
        w_masked = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (new_input[i]) w_masked[i*DATA_WIDTH +: DATA_WIDTH] = input_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_entry = {w_masked, new_input, w_tick, r_ts, r_tag};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts       <= '0;
            r_timer    <= '0;
            r_tag      <= '0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (en) begin
            r_ts <= r_ts + 1'b1;
            if (PERIOD != 0) r_timer <= w_tick ? '0 : r_timer + 1'b1;
            if (w_accept) r_tag <= r_tag + 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop != '1) r_drop <= r_drop + 1'b1;
            end
        end
    end

    rtlola_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_wdata (w_entry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (q_level)
    );

    assign ev.ev_valid    = w_valid;
    assign ev.ev_data     = w_valid ? w_head[O_DATA +: NUM_INPUTS*DATA_WIDTH] : '0;
    assign ev.ev_mask     = w_valid ? w_head[O_MASK +: NUM_INPUTS] : '0;
    assign ev.ev_periodic = w_valid && w_head[O_PER];
    assign ev.ev_ts       = w_valid ? w_head[O_TS +: TS_WIDTH] : '0;
    assign ev.ev_tag      = w_valid ? w_head[O_TAG +: TAG_WIDTH] : '0;

    assign q_push       = w_form;
    assign q_push_valid = w_accept;
    assign q_pop        = w_pop;
    assign overflow     = r_overflow;
    assign drop_count   = r_drop;
endmodule

// File: tb/tb_rtlola_event_queue.sv
// Directed bench for rtlola_event_queue with default parameters (2 x 64-bit, DEPTH 8, PERIOD 1000).
module tb_rtlola_event_queue;
    localparam int NI = 2;
    localparam int DW = 64;
    localparam int DP = 8;
    localparam int TW = 32;
    localparam int GW = 64;
    localparam int PD = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic [NI*DW-1:0]  input_data = '0;
    logic [NI-1:0]     new_input = '0;
    logic              q_push, q_push_valid, q_pop;
    logic [3:0]        q_level;
    logic              overflow;
    logic [15:0]       drop_count;

    int n_checks = 0;
    int n_errors = 0;
    int tb_ts = 0;

    rtlola_event_queue_if #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .TS_WIDTH(TW), .TAG_WIDTH(GW)) evif ();

    rtlola_event_queue #(
        .NUM_INPUTS(NI), .DATA_WIDTH(DW), .DEPTH(DP),
        .TS_WIDTH(TW), .TAG_WIDTH(GW), .PERIOD(PD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .input_data   (input_data),
        .new_input    (new_input),
        .ev           (evif),
        .q_push       (q_push),
        .q_push_valid (q_push_valid),
        .q_pop        (q_pop),
        .q_level      (q_level),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        if (rst && en) tb_ts++;
        #1;
    endtask

    task automatic idle_to(input int ts);
        for (int i = 0; i < 5000 && tb_ts != ts; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        new_input = '0;
        evif.ev_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        en = 1'b1;
        tb_ts = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; new_input = 2'b11; input_data = {64'd5, 64'd6}; evif.ev_ready = 1'b1;
        step();
        n_checks++; if (evif.ev_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b exp 0", evif.ev_valid); end
        n_checks++; if (q_level !== 4'd0) begin n_errors++; $display("FAIL reset_level got %0d exp 0", q_level); end
        n_checks++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin n_errors++; $display("FAIL reset_ovf got %0b/%0d exp 0/0", overflow, drop_count); end
        n_checks++; if (q_push !== 1'b0 || q_pop !== 1'b0) begin n_errors++; $display("FAIL reset_pulses got push %0b pop %0b exp 0 0", q_push, q_pop); end
        n_checks++; if (evif.ev_data !== '0 || evif.ev_tag !== '0) begin n_errors++; $display("FAIL reset_head got %0h/%0h exp 0/0", evif.ev_data, evif.ev_tag); end
    endtask

    task automatic test_single_event();
        do_reset();
        idle_to(499);
        input_data = {64'd1, 64'd1}; new_input = 2'b11;
        #1;
        n_checks++; if (q_push !== 1'b1 || q_push_valid !== 1'b1) begin n_errors++; $display("FAIL single_push got %0b/%0b exp 1/1", q_push, q_push_valid); end
        n_checks++; if (evif.ev_valid !== 1'b0) begin n_errors++; $display("FAIL single_nobypass got %0b exp 0", evif.ev_valid); end
        step();
        new_input = 2'b00;
        n_checks++; if (evif.ev_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid got %0b exp 1", evif.ev_valid); end
        n_checks++; if (evif.ev_data !== {64'd1, 64'd1}) begin n_errors++; $display("FAIL single_data got %0h exp %0h", evif.ev_data, {64'd1, 64'd1}); end
        n_checks++; if (evif.ev_mask !== 2'b11 || evif.ev_periodic !== 1'b0) begin n_errors++; $display("FAIL single_mask got %0b/%0b exp 11/0", evif.ev_mask, evif.ev_periodic); end
        n_checks++; if (evif.ev_ts !== 32'd499) begin n_errors++; $display("FAIL single_ts got %0d exp 499", evif.ev_ts); end
        n_checks++; if (evif.ev_tag !== 64'd0) begin n_errors++; $display("FAIL single_tag got %0d exp 0", evif.ev_tag); end
        n_checks++; if (q_level !== 4'd1) begin n_errors++; $display("FAIL single_level got %0d exp 1", q_level); end
        // Second event: ch0 negative, ch1 carries data but no strobe.
        input_data = {64'h55, 64'hFFFF_FFFF_FFFF_FFF9}; new_input = 2'b01;
        step();
        new_input = 2'b00;
        n_checks++; if (evif.ev_tag !== 64'd0 || q_level !== 4'd2) begin n_errors++; $display("FAIL stall_head got tag %0d level %0d exp 0 2", evif.ev_tag, q_level); end
        evif.ev_ready = 1'b1;
        #1;
        n_checks++; if (q_pop !== 1'b1) begin n_errors++; $display("FAIL pop_pulse got %0b exp 1", q_pop); end
        step();
        n_checks++; if (evif.ev_data !== {64'd0, 64'hFFFF_FFFF_FFFF_FFF9}) begin n_errors++; $display("FAIL mask_data got %0h exp %0h", evif.ev_data, {64'd0, 64'hFFFF_FFFF_FFFF_FFF9}); end
        n_checks++; if (evif.ev_mask !== 2'b01 || evif.ev_ts !== 32'd500 || evif.ev_tag !== 64'd1) begin n_errors++; $display("FAIL mask_fields got %0b/%0d/%0d exp 01/500/1", evif.ev_mask, evif.ev_ts, evif.ev_tag); end
        step();
        n_checks++; if (evif.ev_valid !== 1'b0 || q_level !== 4'd0) begin n_errors++; $display("FAIL drain got %0b/%0d exp 0/0", evif.ev_valid, q_level); end
    endtask

    task automatic test_periodic();
        do_reset();
        evif.ev_ready = 1'b1;
        idle_to(998);
        #1;
        n_checks++; if (q_push !== 1'b0) begin n_errors++; $display("FAIL pre_tick got %0b exp 0", q_push); end
        step();
        n_checks++; if (q_push !== 1'b1) begin n_errors++; $display("FAIL tick_push got %0b exp 1", q_push); end
        step();
        n_checks++; if (evif.ev_valid !== 1'b1 || evif.ev_periodic !== 1'b1 || evif.ev_mask !== 2'b00) begin n_errors++; $display("FAIL tick1 got v%0b p%0b m%0b exp v1 p1 m00", evif.ev_valid, evif.ev_periodic, evif.ev_mask); end
        n_checks++; if (evif.ev_ts !== 32'd999 || evif.ev_tag !== 64'd0) begin n_errors++; $display("FAIL tick1_id got ts %0d tag %0d exp 999 0", evif.ev_ts, evif.ev_tag); end
        idle_to(1999);
        step();
        n_checks++; if (evif.ev_ts !== 32'd1999 || evif.ev_tag !== 64'd1 || evif.ev_periodic !== 1'b1) begin n_errors++; $display("FAIL tick2 got ts %0d tag %0d p %0b exp 1999 1 1", evif.ev_ts, evif.ev_tag, evif.ev_periodic); end
        idle_to(2999);
        input_data = {64'd4, 64'd3}; new_input = 2'b11;
        step();
        new_input = 2'b00;
        n_checks++; if (evif.ev_periodic !== 1'b1 || evif.ev_mask !== 2'b11 || evif.ev_data !== {64'd4, 64'd3}) begin n_errors++; $display("FAIL merged got p%0b m%0b d%0h exp p1 m11 d%0h", evif.ev_periodic, evif.ev_mask, evif.ev_data, {64'd4, 64'd3}); end
        n_checks++; if (evif.ev_ts !== 32'd2999 || evif.ev_tag !== 64'd2 || q_level !== 4'd1) begin n_errors++; $display("FAIL merged_id got ts %0d tag %0d lvl %0d exp 2999 2 1", evif.ev_ts, evif.ev_tag, q_level); end
        step();
        n_checks++; if (q_level !== 4'd0) begin n_errors++; $display("FAIL merged_single got %0d exp 0", q_level); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            input_data = {64'd0, 64'(i)}; new_input = 2'b01;
            #1;
            if (i >= 8) begin
                n_checks++; if (q_push !== 1'b1 || q_push_valid !== 1'b0) begin n_errors++; $display("FAIL drop_pulse%0d got %0b/%0b exp 1/0", i, q_push, q_push_valid); end
            end
            step();
        end
        new_input = 2'b00;
        n_checks++; if (q_level !== 4'd8) begin n_errors++; $display("FAIL full_level got %0d exp 8", q_level); end
        n_checks++; if (overflow !== 1'b1 || drop_count !== 16'd2) begin n_errors++; $display("FAIL ovf got %0b/%0d exp 1/2", overflow, drop_count); end
        evif.ev_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (evif.ev_tag !== 64'(k) || evif.ev_data[63:0] !== 64'(k)) begin n_errors++; $display("FAIL order%0d got tag %0d data %0d exp %0d", k, evif.ev_tag, evif.ev_data[63:0], k); end
            step();
        end
        n_checks++; if (evif.ev_valid !== 1'b0 || overflow !== 1'b1 || drop_count !== 16'd2) begin n_errors++; $display("FAIL ovf_sticky got v%0b o%0b d%0d exp 0 1 2", evif.ev_valid, overflow, drop_count); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            input_data = {64'd0, 64'(i)}; new_input = 2'b01;
            step();
        end
        input_data = {64'd0, 64'd8}; new_input = 2'b01; evif.ev_ready = 1'b1;
        #1;
        n_checks++; if (q_push_valid !== 1'b1 || q_pop !== 1'b1) begin n_errors++; $display("FAIL fullpp_pulse got %0b/%0b exp 1/1", q_push_valid, q_pop); end
        step();
        new_input = 2'b00; evif.ev_ready = 1'b0;
        n_checks++; if (q_level !== 4'd8 || overflow !== 1'b0 || drop_count !== 16'd0) begin n_errors++; $display("FAIL fullpp_level got %0d/%0b/%0d exp 8/0/0", q_level, overflow, drop_count); end
        n_checks++; if (evif.ev_tag !== 64'd1) begin n_errors++; $display("FAIL fullpp_head got %0d exp 1", evif.ev_tag); end
        evif.ev_ready = 1'b1;
        for (int k = 1; k < 9; k++) begin
            n_checks++; if (evif.ev_tag !== 64'(k) || evif.ev_ts !== 32'(k)) begin n_errors++; $display("FAIL fullpp_order%0d got tag %0d ts %0d exp %0d", k, evif.ev_tag, evif.ev_ts, k); end
            step();
        end
    endtask

    task automatic test_enable();
        do_reset();
        input_data = {64'd0, 64'd7}; new_input = 2'b01;
        step();
        en = 1'b0; new_input = 2'b11; evif.ev_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (q_push !== 1'b0 || q_pop !== 1'b0) begin n_errors++; $display("FAIL en_off%0d got push %0b pop %0b exp 0 0", i, q_push, q_pop); end
            step();
        end
        n_checks++; if (q_level !== 4'd1 || evif.ev_tag !== 64'd0) begin n_errors++; $display("FAIL en_hold got lvl %0d tag %0d exp 1 0", q_level, evif.ev_tag); end
        en = 1'b1; evif.ev_ready = 1'b0; new_input = 2'b10; input_data = {64'd2, 64'd0};
        step();
        new_input = 2'b00; evif.ev_ready = 1'b1;
        step();
        n_checks++; if (evif.ev_ts !== 32'd1 || evif.ev_tag !== 64'd1 || evif.ev_mask !== 2'b10) begin n_errors++; $display("FAIL en_frozen got ts %0d tag %0d m %0b exp 1 1 10", evif.ev_ts, evif.ev_tag, evif.ev_mask); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            input_data = {64'd0, 64'd1}; new_input = 2'b01;
            step();
        end
        new_input = 2'b00;
        n_checks++; if (q_level !== 4'd3) begin n_errors++; $display("FAIL pre_rst_level got %0d exp 3", q_level); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (evif.ev_valid !== 1'b0 || q_level !== 4'd0) begin n_errors++; $display("FAIL async_rst got v%0b l%0d exp 0 0", evif.ev_valid, q_level); end
        step();
        rst = 1'b1; tb_ts = 0;
        input_data = {64'd9, 64'd0}; new_input = 2'b10;
        step();
        new_input = 2'b00;
        n_checks++; if (evif.ev_tag !== 64'd0 || evif.ev_ts !== 32'd0 || evif.ev_data !== {64'd9, 64'd0}) begin n_errors++; $display("FAIL post_rst got tag %0d ts %0d data %0h exp 0 0 %0h", evif.ev_tag, evif.ev_ts, evif.ev_data, {64'd9, 64'd0}); end
    endtask

    initial begin
        evif.ev_ready = 1'b0;
        test_reset();
        test_single_event();
        test_periodic();
        test_overflow();
        test_full_push_pop();
        test_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
